regfile_mp: RTL and testbench

Parametrised dual-read, single-write register file with combinational reads, optional write-to-read bypass and a sequenced synchronous bulk clear. Next-generation storage block for the datapath, replacing the fixed 8x8 single-read file. Bulk clear runs one entry per cycle under a busy flag so that large depths do not need a single-cycle wide clear.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_clr_seq.sv | 64 ++++++
 rtl/regfile_mp.sv | 105 ++++++++++
 tb/tb_regfile_mp.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the
// multi-port register file slice.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: bulk-clear sequencer, zeroes
// one entry per cycle while busy is high.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          clr,
  output logic          busy,
  output logic          clr_stb,
  output logic [AW-1:0] idx
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  clr_state_e    st;
  clr_state_e    st_nx;
  logic [AW-1:0] idx_nx;

  // state and clear index registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      st  <= IDLE;
      idx <= '0;
    end else begin
      st  <= st_nx;
      idx <= idx_nx;
    end
  end

  // next state: a clr in IDLE starts the sweep,
  // clr during CLEAR is ignored
  always_comb begin
    st_nx  = st;
    idx_nx = idx;
    unique case (st)
      IDLE: begin
        if (clr) begin
          st_nx  = CLEAR;
          idx_nx = '0;
        end
      end
      CLEAR: begin
        if (idx == LAST) begin
          st_nx  = IDLE;
          idx_nx = '0;
        end else begin
          idx_nx = idx + AW'(1);
        end
      end
      default: begin
        st_nx  = IDLE;
        idx_nx = '0;
      end
    endcase
  end

  assign busy    = (st == CLEAR);
  assign clr_stb = busy;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: dual-read, single-write register file
// with optional write bypass and sequenced clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 8,
  parameter  int BYPASS = 1,
  localparam int AW     = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clr,
  input  logic             en,
  input  logic [AW-1:0]    wsel,
  input  logic [WIDTH-1:0] d,
  input  logic [AW-1:0]    rsel_a,
  input  logic [AW-1:0]    rsel_b,
  output logic [WIDTH-1:0] qa,
  output logic [WIDTH-1:0] qb,
  output logic             busy,
  output logic             wr_drop
);

  localparam bit          BYP = (BYPASS != 0);
  localparam logic [AW:0] DEP = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic          clr_stb;
  logic [AW-1:0] cidx;
  logic          wsel_ok;
  logic          ra_ok;
  logic          rb_ok;
  logic          wr_ok;
  logic          drop_nx;
  logic          byp_a;
  logic          byp_b;

  regfile_clr_seq #(
    .DEPTH (DEPTH)
  ) u_clr_seq (
    .clk     (clk),
    .clr_n   (clr_n),
    .clr     (clr),
    .busy    (busy),
    .clr_stb (clr_stb),
    .idx     (cidx)
  );

  // widened compares so non-power-of-2 depths
  // reject the unused top addresses
  assign wsel_ok = {1'b0, wsel} < DEP;
  assign ra_ok   = {1'b0, rsel_a} < DEP;
  assign rb_ok   = {1'b0, rsel_b} < DEP;

  // a clear request or running clear wins over
  // any write in the same cycle
  assign wr_ok   = en & ~busy & ~clr & wsel_ok;
  assign drop_nx = en & ~wr_ok;

  // storage: async reset, clear sweep, or write
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr_stb) begin
      mem[cidx] <= '0;
    end else if (wr_ok) begin
      mem[wsel] <= d;
    end
  end

  // one-cycle pulse for each discarded write
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= drop_nx;
    end
  end

  assign byp_a = BYP & wr_ok & (rsel_a == wsel);
  assign byp_b = BYP & wr_ok & (rsel_b == wsel);

  // read muxes: out of range, bypass, or stored
  always_comb begin
    qa = '0;
    qb = '0;
    unique case (1'b1)
      !ra_ok:          qa = '0;
      ra_ok && byp_a:  qa = d;
      ra_ok && !byp_a: qa = mem[rsel_a];
      default:         qa = '0;
    endcase
    unique case (1'b1)
      !rb_ok:          qb = '0;
      rb_ok && byp_b:  qb = d;
      rb_ok && !byp_b: qb = mem[rsel_b];
      default:         qb = '0;
    endcase
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: two instances (8 deep bypass,
// 6 deep no bypass) against a reference model.
module tb_regfile_mp;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic [2:0] wsel = '0;
  logic [2:0] rsel_a = '0;
  logic [2:0] rsel_b = '0;
  logic [7:0] d = '0;

  logic [7:0] qa8, qb8, qa6, qb6;
  logic       busy8, busy6, drop8, drop6;

  always #5 clk = ~clk;

  regfile_mp #(
    .WIDTH (8), .DEPTH (8), .BYPASS (1)
  ) u_dut8 (
    .clk     (clk),
    .clr_n   (clr_n),
    .clr     (clr),
    .en      (en),
    .wsel    (wsel),
    .d       (d),
    .rsel_a  (rsel_a),
    .rsel_b  (rsel_b),
    .qa      (qa8),
    .qb      (qb8),
    .busy    (busy8),
    .wr_drop (drop8)
  );

  regfile_mp #(
    .WIDTH (8), .DEPTH (6), .BYPASS (0)
  ) u_dut6 (
    .clk     (clk),
    .clr_n   (clr_n),
    .clr     (clr),
    .en      (en),
    .wsel    (wsel),
    .d       (d),
    .rsel_a  (rsel_a),
    .rsel_b  (rsel_b),
    .qa      (qa6),
    .qb      (qb6),
    .busy    (busy6),
    .wr_drop (drop6)
  );

  int pass_cnt = 0;
  int total = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  // reference model: k=0 is 8 deep bypass,
  // k=1 is 6 deep without bypass
  int         mdep [2] = '{8, 6};
  bit         mbyp [2] = '{1'b1, 1'b0};
  logic [7:0] mm   [2][8];
  int         mptr [2];
  bit         mdr  [2];

  function automatic logic [7:0] mread(int k, int r);
    if (r >= mdep[k]) return 8'h00;
    if (mbyp[k] && en && mptr[k] < 0 && !clr &&
        int'(wsel) < mdep[k] && r == int'(wsel))
      return d;
    return mm[k][r];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) mm[k][i] = 8'h00;
      mptr[k] = -1;
      mdr[k]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      mdr[k] = 1'b0;
      if (mptr[k] >= 0) begin
        mm[k][mptr[k]] = 8'h00;
        mdr[k] = en;
        mptr[k]++;
        if (mptr[k] == mdep[k]) mptr[k] = -1;
      end else if (clr) begin
        mptr[k] = 0;
        mdr[k]  = en;
      end else if (en) begin
        if (int'(wsel) < mdep[k]) mm[k][wsel] = d;
        else mdr[k] = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".qa8"}, qa8, mread(0, rsel_a));
    chk({tag, ".qb8"}, qb8, mread(0, rsel_b));
    chk({tag, ".busy8"}, busy8, mptr[0] >= 0);
    chk({tag, ".drop8"}, drop8, mdr[0]);
    chk({tag, ".qa6"}, qa6, mread(1, rsel_a));
    chk({tag, ".qb6"}, qb6, mread(1, rsel_b));
    chk({tag, ".busy6"}, busy6, mptr[1] >= 0);
    chk({tag, ".drop6"}, drop6, mdr[1]);
  endtask

  // entered at a falling edge with inputs set
  task automatic step(input string tag);
    #1 check_all({tag, "/pre"});
    @(posedge clk);
    model_edge();
    #1 check_all({tag, "/post"});
    @(negedge clk);
  endtask

  typedef struct {
    logic       en;
    logic [2:0] wsel;
    logic [7:0] d;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [7:0] qa8;
    logic [7:0] qb8;
    logic [7:0] qa6;
    logic       dr8;
    logic       dr6;
  } vec_t;

  vec_t tv [7];

  initial begin
    #200000;
    $display("FAIL timeout: no finish by 200000 ns");
    $fatal(1, "timeout");
  end

  initial begin
    int nb8;
    int nb6;

    tv[0] = '{1'b1, 3'd3, 8'hA5, 3'd3, 3'd7,
              8'hA5, 8'h00, 8'h00, 1'b0, 1'b0};
    tv[1] = '{1'b1, 3'd7, 8'h3C, 3'd3, 3'd7,
              8'hA5, 8'h3C, 8'hA5, 1'b0, 1'b1};
    tv[2] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd7,
              8'hA5, 8'h3C, 8'hA5, 1'b0, 1'b0};
    tv[3] = '{1'b1, 3'd2, 8'h11, 3'd2, 3'd2,
              8'h11, 8'h11, 8'h00, 1'b0, 1'b0};
    tv[4] = '{1'b1, 3'd2, 8'h99, 3'd2, 3'd3,
              8'h99, 8'hA5, 8'h11, 1'b0, 1'b0};
    tv[5] = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd7,
              8'h99, 8'h3C, 8'h99, 1'b0, 1'b0};
    tv[6] = '{1'b1, 3'd6, 8'h77, 3'd6, 3'd5,
              8'h77, 8'h00, 8'h00, 1'b0, 1'b1};

    model_reset();
    clr_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("rst.busy8", busy8, 1'b0);
    chk("rst.drop8", drop8, 1'b0);
    chk("rst.busy6", busy6, 1'b0);
    clr_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      rsel_a = 3'(i);
      rsel_b = 3'(7 - i);
      #1 chk("sweep.qa8", qa8, 8'h00);
      chk("sweep.qb8", qb8, 8'h00);
      chk("sweep.qa6", qa6, 8'h00);
      check_all("sweep");
      @(negedge clk);
    end

    for (int i = 0; i < 7; i++) begin
      en     = tv[i].en;
      wsel   = tv[i].wsel;
      d      = tv[i].d;
      rsel_a = tv[i].ra;
      rsel_b = tv[i].rb;
      #1 chk("tv.qa8", qa8, tv[i].qa8);
      chk("tv.qb8", qb8, tv[i].qb8);
      chk("tv.qa6", qa6, tv[i].qa6);
      check_all("tv");
      @(posedge clk);
      model_edge();
      #1 chk("tv.drop8", drop8, tv[i].dr8);
      chk("tv.drop6", drop6, tv[i].dr6);
      @(negedge clk);
    end
    en = 1'b0;

    for (int i = 0; i < 8; i++) begin
      en   = 1'b1;
      wsel = 3'(i);
      d    = 8'h10 + 8'(i);
      step("fill");
    end
    en     = 1'b0;
    rsel_a = 3'd0;
    clr    = 1'b1;
    step("clr_k");
    clr = 1'b0;
    nb8 = busy8 ? 1 : 0;
    nb6 = busy6 ? 1 : 0;
    for (int j = 1; j <= 9; j++) begin
      en     = (j == 3);
      wsel   = 3'd0;
      d      = 8'hFF;
      rsel_a = 3'((j - 1) % 8);
      rsel_b = 3'(j % 8);
      step("clr_run");
      if (busy8) nb8++;
      if (busy6) nb6++;
      if (j == 3) begin
        chk("clr.drop8", drop8, 1'b1);
        chk("clr.drop6", drop6, 1'b1);
      end
    end
    en = 1'b0;
    chk("clr.busy_cycles8", 32'(nb8), 32'd8);
    chk("clr.busy_cycles6", 32'(nb6), 32'd6);
    rsel_a = 3'd0;
    #1 chk("clr.entry0_8", qa8, 8'h00);
    chk("clr.entry0_6", qa6, 8'h00);
    @(negedge clk);

    en = 1'b1; wsel = 3'd5; d = 8'h55;
    step("pre_abort");
    wsel = 3'd1; d = 8'h11;
    step("pre_abort");
    en  = 1'b0;
    clr = 1'b1;
    step("abort_k");
    clr = 1'b0;
    repeat (3) step("abort_run");
    clr_n = 1'b0;
    model_reset();
    #1 chk("abort.busy8", busy8, 1'b0);
    chk("abort.busy6", busy6, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rsel_a = 3'(i);
      rsel_b = 3'(i);
      #0.5 chk("abort.qa8", qa8, 8'h00);
      chk("abort.qa6", qa6, 8'h00);
    end
    @(negedge clk);
    clr_n = 1'b1;
    en = 1'b1; wsel = 3'd5; d = 8'h42;
    step("post_abort");
    en = 1'b0;
    rsel_a = 3'd5;
    #1 chk("abort.rd8", qa8, 8'h42);
    chk("abort.rd6", qa6, 8'h42);
    @(negedge clk);

    repeat (400) begin
      clr    = ($urandom_range(0, 24) == 0);
      en     = $urandom_range(0, 1) == 1;
      wsel   = 3'($urandom_range(0, 7));
      d      = 8'($urandom);
      rsel_a = 3'($urandom_range(0, 7));
      rsel_b = 3'($urandom_range(0, 7));
      step("rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
